// File: rtl/gestion_verin_pwm.sv
// Jack drive PWM with shadowed period/duty/direction, limit-stop blocking and a dead period on
// every direction reversal.
module gestion_verin_pwm (
  input  logic        clk,
  input  logic        raz,
  input  logic        enable,
  input  logic        sens,
  input  logic [15:0] frequency,
  input  logic [15:0] duty,
  input  logic [11:0] butee_g,
  input  logic [11:0] butee_d,
  input  logic [11:0] angle_barre,
  output logic        pwm,
  output logic        sens_out,
  output logic [1:0]  fin_butee,
  output logic        en_marche
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StBlocked = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] freq_sh_q, freq_sh_d;
  logic [15:0] duty_sh_q, duty_sh_d;
  logic        sens_sh_q, sens_sh_d;
  logic        sens_out_q, sens_out_d;
  logic        dead_q, dead_d;
  logic [11:0] angle_q, angle_d;
  logic [1:0]  fin_butee_q, fin_butee_d;
  logic        pwm_q, pwm_d;

  logic boundary;
  logic blocked;
  logic blocked_new;

  always_comb begin
    angle_d     = angle_barre;
    fin_butee_d = {(angle_q >= butee_d), (angle_q <= butee_g)};

    // A zero period makes every cycle a boundary so the shadows keep tracking the inputs.
    boundary    = (freq_sh_q == 16'd0) || (cnt_q == freq_sh_q - 16'd1);
    blocked     = sens_out_q ? fin_butee_q[1] : fin_butee_q[0];
    blocked_new = sens ? fin_butee_q[1] : fin_butee_q[0];

    state_d    = state_q;
    cnt_d      = cnt_q;
    freq_sh_d  = freq_sh_q;
    duty_sh_d  = duty_sh_q;
    sens_sh_d  = sens_sh_q;
    sens_out_d = sens_out_q;
    dead_d     = dead_q;
    pwm_d      = 1'b0;

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = 16'd0;
      dead_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d    = StRun;
          cnt_d      = 16'd0;
          freq_sh_d  = frequency;
          duty_sh_d  = duty;
          sens_sh_d  = sens;
          sens_out_d = sens;
          dead_d     = 1'b0;
        end
        StRun, StBlocked: begin
          cnt_d = boundary ? 16'd0 : cnt_q + 16'd1;
          if (boundary) begin
            freq_sh_d  = frequency;
            duty_sh_d  = duty;
            sens_sh_d  = sens;
            sens_out_d = sens;
            dead_d     = (sens != sens_out_q);
          end
          if (state_q == StRun) begin
            if (blocked) begin
              state_d = StBlocked;
            end else begin
              pwm_d = !dead_q && (freq_sh_q != 16'd0) && (cnt_q < duty_sh_q);
            end
          end else if (boundary && !blocked_new) begin
            // Unblocking is judged against the direction that takes effect at this boundary.
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge raz) begin
    if (raz) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      freq_sh_q   <= 16'd0;
      duty_sh_q   <= 16'd0;
      sens_sh_q   <= 1'b0;
      sens_out_q  <= 1'b0;
      dead_q      <= 1'b0;
      angle_q     <= 12'd0;
      fin_butee_q <= 2'b00;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      freq_sh_q   <= freq_sh_d;
      duty_sh_q   <= duty_sh_d;
      sens_sh_q   <= sens_sh_d;
      sens_out_q  <= sens_out_d;
      dead_q      <= dead_d;
      angle_q     <= angle_d;
      fin_butee_q <= fin_butee_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm       = pwm_q;
  assign sens_out  = sens_out_q;
  assign fin_butee = fin_butee_q;
  assign en_marche = (state_q == StRun);

endmodule
